// File: rtl/i2c_reg_slave_if.sv
// rtl/i2c_reg_slave_if.sv - register-store side bus of the I2C register slave
interface i2c_reg_slave_if;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        busy;

    modport slave (
        output wr_en, wr_addr, wr_data, rd_addr, busy,
        input  rd_data
    );

    modport master (
        input  wr_en, wr_addr, wr_data, rd_addr, busy,
        output rd_data
    );
endinterface

// File: rtl/i2c_reg_slave.sv
// rtl/i2c_reg_slave.sv - I2C slave with 16-bit register pointer; define I2C_SLAVE_READ_EN for the read path
module i2c_reg_slave #(
    parameter logic [6:0] slave_addr = 7'h10
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           i2c_sck,
    inout  wire            i2c_sda,
    i2c_reg_slave_if.slave regs
);
    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, REG_HI, REG_HI_ACK, REG_LO, REG_LO_ACK, WR_DATA, WR_ACK
`ifdef I2C_SLAVE_READ_EN
        , RD_DATA, RD_ACK
`endif
    } state_t;

`ifdef I2C_SLAVE_READ_EN
    localparam logic read_en = 1'b1;
    logic m_nack;
`else
    localparam logic read_en = 1'b0;
`endif

    state_t      state, state_next;
    logic [1:0]  sck_sync, sda_sync;
    logic        sck_q, sda_q;
    logic        sck_cur, sda_cur;
    logic        sck_rise, sck_fall, start_det, stop_det;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift;
    logic [7:0]  reg_hi;
    logic [15:0] ptr;
    logic        byte_done, addr_ok, sda_low;

    assign sck_cur   = sck_sync[1];
    assign sda_cur   = sda_sync[1];
    assign sck_rise  = sck_cur & ~sck_q;
    assign sck_fall  = ~sck_cur & sck_q;
    // SCK must be high on both samples so an SCK edge coinciding with an SDA edge counts as data
    assign start_det = sck_cur & sck_q & sda_q & ~sda_cur;
    assign stop_det  = sck_cur & sck_q & ~sda_q & sda_cur;
    assign byte_done = sck_fall && (bit_cnt == 4'd8);
    assign addr_ok   = (shift[7:1] == slave_addr) && (!shift[0] || read_en);

    assign regs.rd_addr = ptr;
    assign i2c_sda      = sda_low ? 1'b0 : 1'bz;

    // Two-flop synchronizers plus a history stage; left unreset so reset cannot fabricate bus edges
    always_ff @(posedge clock) begin
        sck_sync <= {sck_sync[0], i2c_sck};
        sda_sync <= {sda_sync[0], i2c_sda};
        sck_q    <= sck_sync[1];
        sda_q    <= sda_sync[1];
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode and open-drain SDA pull-down
    always_comb begin
        state_next = state;
        sda_low    = 1'b0;
        if (start_det) begin
            state_next = DEV_ADDR;
        end else if (stop_det) begin
            state_next = IDLE;
        end else begin
            case (state)
                DEV_ADDR:   if (byte_done) state_next = addr_ok ? DEV_ACK : IDLE;
                DEV_ACK: if (sck_fall) begin
`ifdef I2C_SLAVE_READ_EN
                    state_next = shift[0] ? RD_DATA : REG_HI;
`else
                    state_next = REG_HI;
`endif
                end
                REG_HI:     if (byte_done) state_next = REG_HI_ACK;
                REG_HI_ACK: if (sck_fall)  state_next = REG_LO;
                REG_LO:     if (byte_done) state_next = REG_LO_ACK;
                REG_LO_ACK: if (sck_fall)  state_next = WR_DATA;
                WR_DATA:    if (byte_done) state_next = WR_ACK;
                WR_ACK:     if (sck_fall)  state_next = WR_DATA;
`ifdef I2C_SLAVE_READ_EN
                RD_DATA:    if (byte_done) state_next = RD_ACK;
                RD_ACK:     if (sck_fall)  state_next = m_nack ? IDLE : RD_DATA;
`endif
                default: ;
            endcase
        end
        case (state)
            DEV_ACK, REG_HI_ACK, REG_LO_ACK, WR_ACK: sda_low = 1'b1;
`ifdef I2C_SLAVE_READ_EN
            RD_DATA: sda_low = ~shift[7];
`endif
            default: ;
        endcase
    end

    // Bit counting, shifting, pointer maintenance and register-store strobes
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt      <= 4'd0;
            shift        <= 8'h00;
            reg_hi       <= 8'h00;
            ptr          <= 16'h0000;
            regs.busy    <= 1'b0;
            regs.wr_en   <= 1'b0;
            regs.wr_addr <= 16'h0000;
            regs.wr_data <= 8'h00;
`ifdef I2C_SLAVE_READ_EN
            m_nack       <= 1'b0;
`endif
        end else begin
            regs.wr_en <= 1'b0;
            if (stop_det) regs.busy <= 1'b0;
            if (start_det || stop_det) begin
                bit_cnt <= 4'd0;
            end else begin
                case (state)
                    DEV_ADDR, REG_HI, REG_LO, WR_DATA: begin
                        if (sck_rise && bit_cnt != 4'd8) begin
                            shift   <= {shift[6:0], sda_cur};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (state == WR_DATA && bit_cnt == 4'd7) begin
                                regs.wr_en   <= 1'b1;
                                regs.wr_addr <= ptr;
                                regs.wr_data <= {shift[6:0], sda_cur};
                                ptr          <= ptr + 16'd1;
                            end
                        end
                        if (byte_done) begin
                            bit_cnt <= 4'd0;
                            if (state == DEV_ADDR && addr_ok) regs.busy <= 1'b1;
                            if (state == REG_HI) reg_hi <= shift;
                        end
                    end
                    DEV_ACK:    if (sck_fall) shift <= regs.rd_data;
                    REG_LO_ACK: if (sck_fall) ptr <= {reg_hi, shift};
`ifdef I2C_SLAVE_READ_EN
                    RD_DATA: begin
                        if (sck_rise && bit_cnt != 4'd8) bit_cnt <= bit_cnt + 4'd1;
                        if (sck_fall && bit_cnt != 4'd0 && bit_cnt != 4'd8) shift <= {shift[6:0], 1'b0};
                        if (byte_done) bit_cnt <= 4'd0;
                    end
                    RD_ACK: begin
                        if (sck_rise) begin
                            m_nack <= sda_cur;
                            if (!sda_cur) ptr <= ptr + 16'd1;
                        end
                        if (sck_fall && !m_nack) shift <= regs.rd_data;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_reg_slave.sv
// tb/tb_i2c_reg_slave.sv - self-checking bench for i2c_reg_slave
module tb_i2c_reg_slave;
    logic clock = 1'b0;
    logic reset;
    logic sck;
    logic m_sda;
    wire  i2c_sda;

    always #5 clock = ~clock;

    pullup (i2c_sda);
    assign i2c_sda = m_sda ? 1'bz : 1'b0;

    i2c_reg_slave_if bus ();

    i2c_reg_slave #(.slave_addr(7'h10)) dut (
        .clock   (clock),
        .reset   (reset),
        .i2c_sck (sck),
        .i2c_sda (i2c_sda),
        .regs    (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_q[$];
    logic [23:0] act_q[$];
    logic [23:0] exp_e;
    logic [15:0] model_ptr;
    logic        prev_wr = 1'b0;
    bit          no_drive = 1'b0;
    logic        ack;
    logic [7:0]  tmp, v0, v1;
    int          n0;

    function automatic logic [7:0] store_val(input logic [15:0] a);
        case (a)
            16'h0100: return 8'hA5;
            16'h0101: return 8'h3C;
            default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    always @(posedge clock) bus.rd_data <= store_val(bus.rd_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            prev_wr = 1'b0;
        end else begin
            if (bus.wr_en) begin
                chk("wr_en_width", {31'd0, prev_wr}, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected actual=%h required=none", {bus.wr_addr, bus.wr_data});
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("wr_txn", {8'd0, bus.wr_addr, bus.wr_data}, {8'd0, exp_e});
                end
                act_q.push_back({bus.wr_addr, bus.wr_data});
            end
            prev_wr = bus.wr_en;
            if (no_drive && m_sda) chk("sda_not_driven", {31'd0, i2c_sda}, 1);
        end
    end

    task automatic q();
        repeat (5) @(posedge clock);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; q(); sck = 1'b1; q(); m_sda = 1'b0; q(); sck = 1'b0; q();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; q(); sck = 1'b1; q(); m_sda = 1'b1; q();
    endtask

    task automatic put_bit(input logic b);
        m_sda = b; q(); sck = 1'b1; q(); q(); sck = 1'b0; q();
    endtask

    task automatic get_bit(output logic b);
        m_sda = 1'b1; q(); sck = 1'b1; q(); b = i2c_sda; q(); sck = 1'b0; q();
    endtask

    task automatic put_byte(input logic [7:0] v, output logic a);
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
        get_bit(a);
    endtask

    task automatic get_byte(output logic [7:0] v, input logic a);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            v[i] = b;
        end
        put_bit(a);
    endtask

    task automatic addr_phase(input logic [7:0] hi, input logic [7:0] lo);
        logic a;
        put_byte(8'h20, a); chk("dev_ack", {31'd0, a}, 0);
        put_byte(hi, a);    chk("hi_ack", {31'd0, a}, 0);
        put_byte(lo, a);    chk("lo_ack", {31'd0, a}, 0);
        model_ptr = {hi, lo};
    endtask

    task automatic wr_data_byte(input logic [7:0] v);
        logic a;
        exp_q.push_back({model_ptr, v});
        model_ptr = model_ptr + 16'd1;
        put_byte(v, a);
        chk("data_ack", {31'd0, a}, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; sck = 1'b1; m_sda = 1'b1; model_ptr = 16'h0000;
        repeat (4) @(posedge clock);
        #1;
        chk("rst_wr_en", {31'd0, bus.wr_en}, 0);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_wr_addr", {16'd0, bus.wr_addr}, 0);
        chk("rst_wr_data", {24'd0, bus.wr_data}, 0);
        chk("rst_rd_addr", {16'd0, bus.rd_addr}, 0);
        chk("rst_sda", {31'd0, i2c_sda}, 1);
        reset = 1'b0;
        q();

        i2c_start(); addr_phase(8'h30, 8'h0A); wr_data_byte(8'h5C);
        chk("t1_busy_in_txn", {31'd0, bus.busy}, 1);
        i2c_stop(); q();
        chk("t1_busy_after_stop", {31'd0, bus.busy}, 0);
        chk("t1_pending", exp_q.size(), 0);
        chk("t1_lit", {8'd0, act_q[$]}, 32'h00300A5C);
        chk("t1_ptr", {16'd0, bus.rd_addr}, {16'd0, model_ptr});

        i2c_start(); addr_phase(8'hFF, 8'hFF); wr_data_byte(8'h11); wr_data_byte(8'h22);
        i2c_stop(); q();
        chk("t2_pending", exp_q.size(), 0);
        chk("t2_lit0", {8'd0, act_q[$-1]}, 32'h00FFFF11);
        chk("t2_lit1", {8'd0, act_q[$]}, 32'h00000022);
        chk("t2_ptr", {16'd0, bus.rd_addr}, {16'd0, model_ptr});

        n0 = act_q.size();
        no_drive = 1'b1;
        i2c_start();
        put_byte(8'h22, ack); chk("t3_nack", {31'd0, ack}, 1);
        chk("t3_busy", {31'd0, bus.busy}, 0);
        put_byte(8'h30, ack); chk("t3_nack_next", {31'd0, ack}, 1);
        i2c_stop(); q();
        no_drive = 1'b0;
        chk("t3_busy_end", {31'd0, bus.busy}, 0);
        chk("t3_no_wr", act_q.size(), n0);

        n0 = act_q.size();
        i2c_start(); addr_phase(8'h12, 8'h34); wr_data_byte(8'hAA);
        tmp = 8'hBB;
        for (int i = 7; i >= 4; i--) put_bit(tmp[i]);
        i2c_stop(); q();
        chk("t4_one_wr", act_q.size(), n0 + 1);
        chk("t4_pending", exp_q.size(), 0);
        chk("t4_ptr", {16'd0, bus.rd_addr}, {16'd0, model_ptr});
        chk("t4_ptr_lit", {16'd0, bus.rd_addr}, 32'h1235);
        i2c_start(); addr_phase(model_ptr[15:8], model_ptr[7:0]); wr_data_byte(8'hCC);
        i2c_stop(); q();
        chk("t4_next_lit", {8'd0, act_q[$]}, 32'h001235CC);

        i2c_start(); addr_phase(8'h01, 8'h00);
        i2c_start();
`ifdef I2C_SLAVE_READ_EN
        put_byte(8'h21, ack); chk("t5_rd_ack", {31'd0, ack}, 0);
        get_byte(v0, 1'b0);
        chk("t5_rd0", {24'd0, v0}, {24'd0, store_val(model_ptr)});
        chk("t5_rd0_lit", {24'd0, v0}, 32'hA5);
        model_ptr = model_ptr + 16'd1;
        get_byte(v1, 1'b1);
        chk("t5_rd1", {24'd0, v1}, {24'd0, store_val(model_ptr)});
        chk("t5_rd1_lit", {24'd0, v1}, 32'h3C);
        i2c_stop(); q();
        chk("t5_ptr_lit", {16'd0, bus.rd_addr}, 32'h0101);
`else
        no_drive = 1'b1;
        put_byte(8'h21, ack);
        no_drive = 1'b0;
        chk("t5_rd_nack", {31'd0, ack}, 1);
        i2c_stop(); q();
        chk("t5_ptr_lit", {16'd0, bus.rd_addr}, 32'h0100);
`endif
        chk("t5_ptr", {16'd0, bus.rd_addr}, {16'd0, model_ptr});
        chk("t5_busy_end", {31'd0, bus.busy}, 0);

        i2c_start();
        put_byte(8'h20, ack); put_byte(8'h40, ack);
        tmp = 8'h41;
        for (int i = 7; i >= 0; i--) put_bit(tmp[i]);
        m_sda = 1'b1; #1;
        chk("t6_acking", {31'd0, i2c_sda}, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("t6_sda_rel", {31'd0, i2c_sda}, 1);
        chk("t6_busy", {31'd0, bus.busy}, 0);
        chk("t6_wr_en", {31'd0, bus.wr_en}, 0);
        chk("t6_wr_addr", {16'd0, bus.wr_addr}, 0);
        chk("t6_wr_data", {24'd0, bus.wr_data}, 0);
        model_ptr = 16'h0000;
        chk("t6_rd_addr", {16'd0, bus.rd_addr}, {16'd0, model_ptr});
        reset = 1'b0;
        q(); sck = 1'b1; q(); sck = 1'b0; q();
        chk("t6_ignored", {31'd0, i2c_sda}, 1);
        i2c_stop(); q();
        i2c_start(); addr_phase(8'h50, 8'h60); wr_data_byte(8'h77);
        i2c_stop(); q();
        chk("t6_lit", {8'd0, act_q[$]}, 32'h00506077);
        chk("all_writes_seen", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_reg_slave.md
I2C_REG_SLAVE -- requirements
Module: i2c_reg_slave

Interface
- REQ-001: Parameter slave_addr, default 7'h10, is the 7-bit I2C device address the block responds to.
- REQ-002: clock  input  1  system clock; SCK is at most 1/8 of its frequency.
- REQ-003: reset  input  1  synchronous, active-high reset.
- REQ-004: i2c_sck  input  1  I2C clock from the bus master; never driven.
- REQ-005: i2c_sda  inout  1  I2C data, open-drain: driven 0 or high-Z only, never driven 1.
- REQ-006: wr_en  output  1  one-cycle register-write strobe.
- REQ-007: wr_addr  output  16  register address for the wr_en write.
- REQ-008: wr_data  output  8  register data for the wr_en write.
- REQ-009: rd_addr  output  16  current register pointer, presented to the external register store.
- REQ-010: rd_data  input  8  register contents at rd_addr, valid 1 clock after rd_addr changes.
- REQ-011: busy  output  1  high from an address match until the next STOP.

Function
- REQ-012: i2c_sck and i2c_sda SHALL each pass through a 2-FF synchronizer; all edge and condition detection SHALL use the synchronized values.
- REQ-013: START SHALL be detected as SDA 1->0 while SCK is high; STOP as SDA 0->1 while SCK is high. Both SHALL be honoured in every state, and a STOP or START SHALL abort any byte in progress.
- REQ-014: Incoming bits SHALL be sampled on the SCK rising edge, MSB first; SDA output changes SHALL occur only on the SCK falling edge.
- REQ-015: State machine states: IDLE, DEV_ADDR, DEV_ACK, REG_HI, REG_HI_ACK, REG_LO, REG_LO_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
- REQ-016: Any START SHALL enter DEV_ADDR. This includes a repeated START.
- REQ-017: After 8 bits in DEV_ADDR, if bits[7:1] == slave_addr the block SHALL ACK: drive SDA low from the falling edge after bit 8 to the falling edge after bit 9. On mismatch it SHALL release SDA and go to IDLE.
- REQ-018: After the address ACK: R/W=0 SHALL go to REG_HI; R/W=1 SHALL go to RD_DATA.
- REQ-019: REG_HI and REG_LO SHALL each receive one byte and ACK it. After REG_LO_ACK the pointer SHALL be {hi,lo}, and rd_addr SHALL update on the falling edge that ends the ACK.
- REQ-020: WR_DATA SHALL receive and ACK each data byte. wr_en SHALL pulse for exactly one clock, in the clock after the 8th data bit is sampled, with wr_addr = pointer and wr_data = byte.
- REQ-021: After each write the pointer SHALL increment by 1, and writes SHALL continue until STOP or START.
- REQ-022: RD_DATA SHALL load rd_data into the shift register on the SCK falling edge that begins the byte, then shift it out MSB first; a 1 bit SHALL release SDA.
- REQ-023: In RD_ACK the block SHALL release SDA. A master ACK (0) SHALL increment the pointer and return to RD_DATA; a master NACK (1) SHALL go to IDLE and wait for STOP or START.
- REQ-024: The pointer SHALL be 16 bits and wrap 16'hFFFF -> 16'h0000 with no flag.
- REQ-025: A data byte cut short by STOP or START SHALL produce no wr_en and no pointer change.
- REQ-026: A START and STOP detected in the same clock cannot occur, because both require an SDA edge; an SCK edge coincident with an SDA edge SHALL be treated as a data edge, not a condition.

Reset
- REQ-027: reset SHALL put the state machine in IDLE, release SDA, and drive wr_en=0, busy=0, wr_addr=16'h0000, wr_data=8'h00, rd_addr=16'h0000.
- REQ-028: reset asserted mid-transfer SHALL take effect on the next clock edge. The block SHALL then ignore the bus until the next START.

Configuration
- REQ-029: Macro I2C_SLAVE_READ_EN: when defined, reads SHALL be supported as in REQ-018, REQ-022 and REQ-023.
- REQ-030: When I2C_SLAVE_READ_EN is undefined, RD_DATA and RD_ACK SHALL be absent, rd_addr SHALL still track the pointer, and an address byte with R/W=1 SHALL be NACKed and return to IDLE.

Verification
- REQ-031: Write S,0x20,0x30,0x0A,0x5C,P -> ACK on all 4 bytes; one wr_en with wr_addr=16'h300A and wr_data=8'h5C; busy falls at STOP.
- REQ-032: Burst write S,0x20,0xFF,0xFF,0x11,0x22,P -> wr_en at 16'hFFFF=8'h11, then at 16'h0000=8'h22.
- REQ-033: Address 0x22 (device 0x11) -> no ACK, SDA never driven, no wr_en, busy stays 0.
- REQ-034: With I2C_SLAVE_READ_EN defined: S,0x20,0x01,0x00,Sr,0x21, read 2 bytes (ACK, then NACK), P, with the store returning 0xA5 at 0x0100 and 0x3C at 0x0101 -> bits A5 then 3C on SDA; rd_addr ends at 16'h0101. Without I2C_SLAVE_READ_EN: 0x21 is NACKed.
- REQ-035: STOP after 4 bits of a data byte -> no wr_en; the next write uses the unchanged pointer.
- REQ-036: reset pulsed during REG_LO_ACK -> SDA released on the next clock, all outputs at reset values; a following full write completes normally.
